// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM encoding, parity helper.
// Used by both the transmitter and receiver sides of the link.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_FRAME_BITS   = 11;
  localparam int UART_CLKS_PER_BIT = 5208;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic parity_bit(
    input uart_byte_t d,
    input logic       odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_parity_transmitter_if.sv
// Host-side byte handshake plus serial line of the UART transmitter.
// master = byte source, slave = transmitter.
interface uart_tx_parity_transmitter_if;
  import uart_pkg::*;

  logic       tx_start_in;
  uart_byte_t tx_data_in;
  logic       tx_out;
  logic       tx_busy_out;
  logic       tx_done_out;

  modport master (
    output tx_start_in,
    output tx_data_in,
    input  tx_out,
    input  tx_busy_out,
    input  tx_done_out
  );

  modport slave (
    input  tx_start_in,
    input  tx_data_in,
    output tx_out,
    output tx_busy_out,
    output tx_done_out
  );

endinterface

// File: rtl/uart_baud_tick_gen.sv
// Bit-period counter: pulses bit_end on the last cycle of each bit.
// Shared with the receiver for its sampling tick.
module uart_baud_tick_gen #(
  parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = enable && (cnt == LAST);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_parity_transmitter.sv
// UART transmitter: start, 8 data bits LSB-first, parity, stop.
// All outputs registered from next-state values.
module uart_tx_parity_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0
) (
  input logic Clk,
  input logic reset,
  uart_tx_parity_transmitter_if.slave tx
);

  localparam logic ODD = (PARITY_ODD != 0);

  uart_state_e state, state_nxt;
  uart_byte_t  shift, shift_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        par, par_nxt;
  logic        tx_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic        baud_clr;
  logic        bit_end;

  uart_baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clk    (Clk),
    .reset  (reset),
    .clear  (baud_clr),
    .enable (state != IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    idx_nxt   = idx;
    par_nxt   = par;
    done_nxt  = 1'b0;
    baud_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx.tx_start_in && !tx.tx_busy_out) begin
          state_nxt = START;
          shift_nxt = tx.tx_data_in;
          par_nxt   = parity_bit(tx.tx_data_in, ODD);
          idx_nxt   = '0;
          baud_clr  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift >> 1;
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level follows the state being entered, so it is registered.
  always_comb begin
    tx_nxt = 1'b1;
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      shift          <= '0;
      idx            <= '0;
      par            <= 1'b0;
      tx.tx_out      <= 1'b1;
      tx.tx_busy_out <= 1'b0;
      tx.tx_done_out <= 1'b0;
    end else begin
      shift          <= shift_nxt;
      idx            <= idx_nxt;
      par            <= par_nxt;
      tx.tx_out      <= tx_nxt;
      tx.tx_busy_out <= busy_nxt;
      tx.tx_done_out <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_parity_transmitter.sv
// Bench for uart_tx_parity_transmitter: even and odd parity instances,
// frame table plus busy, back-to-back and reset corner sequences.
module tb_uart_tx_parity_transmitter;

  localparam int CPB = 4;

  logic Clk;
  logic reset;

  uart_tx_parity_transmitter_if bus0 ();
  uart_tx_parity_transmitter_if bus1 ();

  uart_tx_parity_transmitter #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (0)
  ) dut0 (
    .Clk  (Clk),
    .reset(reset),
    .tx   (bus0.slave)
  );

  uart_tx_parity_transmitter #(
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (1)
  ) dut1 (
    .Clk  (Clk),
    .reset(reset),
    .tx   (bus1.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? bus1.tx_out : bus0.tx_out;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? bus1.tx_busy_out : bus0.tx_busy_out;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel != 0) ? bus1.tx_done_out : bus0.tx_done_out;
  endfunction

  function automatic logic [7:0] data_of(input int sel);
    return (sel != 0) ? bus1.tx_data_in : bus0.tx_data_in;
  endfunction

  task automatic drive(input int sel, input logic s, input logic [7:0] d);
    if (sel != 0) begin
      bus1.tx_start_in = s;
      bus1.tx_data_in  = d;
    end else begin
      bus0.tx_start_in = s;
      bus0.tx_data_in  = d;
    end
  endtask

  task automatic launch(input int sel, input logic [7:0] d,
                        input logic [10:0] frame);
    drive(sel, 1'b1, d);
    exp_q.push_back(frame);
  endtask

  // Walks one frame from its first low cycle to the done cycle.
  task automatic observe(input int sel, input string tag, input int poke_at);
    logic [10:0] exp;
    logic [10:0] got;
    logic [3:0]  b;
    int          glitch;
    int          busy_bad;
    int          dones;
    got      = '0;
    glitch   = 0;
    busy_bad = 0;
    dones    = 0;
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 32'(0), 32'(1));
      exp = '1;
    end else begin
      exp = exp_q.pop_front();
    end
    for (int i = 0; i < 11 * CPB; i++) begin
      @(negedge Clk);
      if (i == 0) drive(sel, 1'b0, ~data_of(sel));
      if (i == poke_at) drive(sel, 1'b1, 8'hFF);
      if (i == poke_at + 3) drive(sel, 1'b0, 8'hFF);
      b = 4'(i / CPB);
      if (i % CPB == CPB / 2) got[b] = tx_of(sel);
      if (tx_of(sel) !== exp[b]) glitch++;
      if (busy_of(sel) !== 1'b1) busy_bad++;
      if (done_of(sel) !== 1'b0) dones++;
    end
    chk({tag, " frame"}, 32'(got), 32'(exp));
    chk({tag, " bit stability"}, 32'(glitch), 32'(0));
    chk({tag, " busy in frame"}, 32'(busy_bad), 32'(0));
    chk({tag, " early done"}, 32'(dones), 32'(0));
    chk({tag, " rx parity"}, 32'((^got[9:1]) ^ (sel != 0)), 32'(0));
    @(negedge Clk);
    chk({tag, " done pulse"}, 32'(done_of(sel)), 32'(1));
    chk({tag, " busy fall"}, 32'(busy_of(sel)), 32'(0));
    chk({tag, " line idle"}, 32'(tx_of(sel)), 32'(1));
  endtask

  task automatic idle_check(input int sel, input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (tx_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0 ||
          done_of(sel) !== 1'b0) bad++;
    end
    chk({tag, " idle"}, 32'(bad), 32'(0));
  endtask

  initial begin
    vt[0] = '{0, 8'hA5, 11'b10101001010};
    vt[1] = '{1, 8'h07, {1'b1, 1'b0, 8'h07, 1'b0}};
    vt[2] = '{0, 8'h01, {1'b1, 1'b1, 8'h01, 1'b0}};
    vt[3] = '{1, 8'h80, {1'b1, 1'b0, 8'h80, 1'b0}};
    vt[4] = '{1, 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}};
    vt[5] = '{0, 8'h6B, {1'b1, 1'b1, 8'h6B, 1'b0}};
    vt[6] = '{1, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}};

    reset = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge Clk);
    chk("reset tx_out", 32'(bus0.tx_out), 32'(1));
    chk("reset busy", 32'(bus0.tx_busy_out), 32'(0));
    chk("reset done", 32'(bus0.tx_done_out), 32'(0));
    reset = 1'b1;
    idle_check(0, "post-reset dut0", 20);
    idle_check(1, "post-reset dut1", 1);

    for (int k = 0; k < 7; k++) begin
      launch(vt[k].sel, vt[k].data, vt[k].frame);
      observe(vt[k].sel, $sformatf("vec%0d", k), -1);
      @(negedge Clk);
      chk($sformatf("vec%0d done single", k), 32'(done_of(vt[k].sel)),
          32'(0));
    end

    launch(0, 8'h00, {1'b1, 1'b0, 8'h00, 1'b0});
    observe(0, "busy-ignore", 10);
    idle_check(0, "busy-ignore", 20);

    launch(0, 8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0});
    observe(0, "b2b first", -1);
    launch(0, 8'hC3, {1'b1, 1'b0, 8'hC3, 1'b0});
    observe(0, "b2b second", -1);
    idle_check(0, "b2b", 3);

    launch(0, 8'h5A, {1'b1, 1'b0, 8'h5A, 1'b0});
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      if (i == 0) drive(0, 1'b0, 8'h5A);
    end
    void'(exp_q.pop_front());
    chk("mid-frame busy", 32'(bus0.tx_busy_out), 32'(1));
    reset = 1'b0;
    #1;
    chk("async reset tx_out", 32'(bus0.tx_out), 32'(1));
    chk("async reset busy", 32'(bus0.tx_busy_out), 32'(0));
    repeat (2) @(negedge Clk);
    reset = 1'b1;
    idle_check(0, "after abort", 4);
    launch(0, 8'h5A, {1'b1, 1'b0, 8'h5A, 1'b0});
    observe(0, "fresh 5A", -1);

    @(negedge Clk);
    reset = 1'b0;
    launch(0, 8'h6B, {1'b1, 1'b1, 8'h6B, 1'b0});
    @(posedge Clk);
    reset <= 1'b1;
    @(negedge Clk);
    chk("start at release tx", 32'(bus0.tx_out), 32'(1));
    chk("start at release busy", 32'(bus0.tx_busy_out), 32'(0));
    observe(0, "after release", -1);
    idle_check(0, "final", 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_parity_transmitter.md
Name: uart_tx_parity_transmitter

Overview:
- Transmit side of the UART link; generates the frame that the receiver's SIPO and parity-check path consumes.
- Serialises one 8-bit byte per request as: start bit (0), 8 data bits LSB-first, one parity bit, one stop bit (1).
- Parity is even by default: parity bit = XOR of the data bits, so the receiver's check passes on clean frames.
- Sits between the host-side byte source and the serial TX pin.

Parameters:
- CLKS_PER_BIT, 5208: Clk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
- PARITY_ODD, 0: 0 = even parity (XOR of data), 1 = odd parity (inverted XOR).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- tx_start_in  input  1  request to send tx_data_in; sampled only in IDLE.
- tx_data_in  input  8  byte to transmit; latched on accepted start.
- tx_out  output  1  serial line, registered; idles high.
- tx_busy_out  output  1  high from the cycle after acceptance until the frame completes.
- tx_done_out  output  1  single-cycle pulse when the stop bit has fully elapsed.

Behaviour:
- Reset (reset=0, any time, including mid-frame):
  - tx_out=1, tx_busy_out=0, tx_done_out=0; state=IDLE; bit counter, baud counter and shift register cleared.
  - A frame in flight is abandoned and never resumed.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1.
  - If tx_start_in=1 in cycle N: latch tx_data_in into the shift register, compute and latch the parity bit, clear the baud counter, and go to START.
  - tx_out=0 and tx_busy_out=1 from cycle N+1.
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1; each bit occupies exactly CLKS_PER_BIT cycles.
  - State advances when the counter equals CLKS_PER_BIT-1; the counter wraps to 0 on every advance.
- START: drive 0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - Drive shift[0]; shift right at each bit boundary.
  - The 3-bit index counts 0..7; after bit index 7 completes, go to PARITY.
- PARITY: drive the latched parity bit (^data, inverted when PARITY_ODD=1) for one bit time.
- STOP:
  - Drive 1 for one bit time.
  - At its final cycle go to IDLE, deassert tx_busy_out, and pulse tx_done_out for exactly one cycle.
  - Both output changes are registered, so they are visible in the cycle following the last stop cycle.
- Frame length: exactly 11*CLKS_PER_BIT cycles from the first low cycle of tx_out to tx_busy_out falling.
- Handshake rules:
  - tx_start_in is ignored while tx_busy_out=1 or the state is not IDLE; no queueing.
  - Back-to-back start is allowed: a start asserted in the cycle tx_done_out is high is accepted, and the next start bit begins the following cycle.
  - tx_data_in changes after acceptance have no effect on the frame in flight.
- Simultaneous events: reset deassertion and tx_start_in in the same edge; the start is not accepted until the first clock after reset is released.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding for IDLE/START/DATA/PARITY/STOP.
  - UART_DATA_BITS=8 and UART_FRAME_BITS=11.
  - Default CLKS_PER_BIT for the board clock.
  - The receiver uses the same package.
- One natural sub-module: uart_baud_tick_gen.
  - Parameterised by CLKS_PER_BIT; clear input; outputs a one-cycle bit_end pulse.
  - Reusable by the receiver for its sampling tick.

Test Plan (CLKS_PER_BIT=4 in simulation):
- Reset then idle 20 cycles -> tx_out=1, tx_busy_out=0, tx_done_out never pulses.
- Send 0xA5 (even parity) -> tx_out sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0,1; total 44 low-to-done cycles; one tx_done_out pulse.
- Send 0x07 with PARITY_ODD=1 -> data bits 1,1,1,0,0,0,0,0; parity bit 0; receiver model reports parity match.
- Assert tx_start_in with 0xFF while busy sending 0x00 -> second request ignored; only the 0x00 frame (parity 0) appears; one done pulse.
- Back-to-back 0x3C then 0xC3, second start raised in the tx_done_out cycle -> 22 contiguous bit times, no idle gap beyond one cycle.
- Drive reset low during DATA bit 3 of 0x5A -> tx_out=1 and tx_busy_out=0 immediately (asynchronous); after release, a fresh 0x5A frame transmits correctly from its start bit.
